datapath_mem_hs: RTL and testbench
==================================

Name: datapath_mem_hs

Overview:
Parametrised successor to the team's multicycle RV datapath (PC, IR/old-PC latches, register file, imm extend, A/B muxes, ALU, ALU-out, MDR, result mux).
- Adds a valid/ready memory handshake with a request FSM, so memory may take any number of cycles.
- Adds sub-word loads/stores with byte enables and sign/zero extension, plus misalignment detection.
- Sits between the main control FSM and the unified memory; the controller waits on mem_done instead of assuming 1-cycle memory.

Parameters:
XLEN, 32, datapath width; 32 or 64 only.
NUM_REGS, 32, register count; x0 hard-wired to zero.
RESET_PC, 0, PC value after reset.
TIMEOUT_CYCLES, 255, request abort limit; used only with MEM_TIMEOUT_EN.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
pc_write  in  1  load PC from result
adr_src  in  1  memory address select: 0=PC, 1=result
result_src  in  2  0=alu_out, 1=MDR, 2=alu_result
alu_control  in  4  ALU operation, same encoding as existing ALU
alu_src_a  in  2  0=PC, 1=old_pc, 2=latched rs1
alu_src_b  in  2  0=latched rs2, 1=imm, 2=4
imm_src  in  3  immediate format
reg_write  in  1  register file write
mem_start  in  1  1-cycle request launch
mem_we  in  1  1=store
mem_fetch  in  1  read result goes to IR/old_pc, not MDR
mem_size  in  2  0=byte, 1=half, 2=word, 3=dword
mem_unsigned  in  1  zero-extend loads
mem_req  out  1  request valid
mem_we_o  out  1  request is a write
mem_addr  out  XLEN  aligned request address (low log2(XLEN/8) bits zero)
mem_wdata  out  XLEN  lane-replicated store data
mem_be  out  XLEN/8  byte enables
mem_rdata  in  XLEN  read data
mem_ready  in  1  completes request when sampled with mem_req=1
instr  out  32  instruction register
zero  out  1  ALU zero flag
busy  out  1  request in flight
mem_done  out  1  1-cycle completion pulse
misalign_fault  out  1  1-cycle pulse, request rejected
bus_error  out  1  1-cycle pulse, request timed out (feature only)

Behaviour:
- Reset (rst=0 at posedge):
  - PC=RESET_PC.
  - IR, old_pc, MDR, alu_out, rs latches, all registers = 0.
  - FSM=IDLE; all outputs 0. Any in-flight request is dropped.
- FSM states: IDLE, REQ.
- IDLE, mem_start=1, aligned:
  - Capture address offset, size, we, fetch, unsigned, and store data (latched rs2).
  - Next state REQ.
- REQ:
  - mem_req=1, busy=1; address, data and enables held stable.
  - Posedge with mem_ready=1: read data captured, state returns to IDLE, mem_done=1 in the following cycle.
- Minimum latency: mem_start at cycle N → mem_req at N+1 → mem_done at N+2 if mem_ready is high at N+1.
- Misaligned request rejected: no state change, misalign_fault pulse next cycle, no mem_done. Misaligned means:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - dword with addr[2:0]!=0;
  - dword when XLEN=32.
- Ignored inputs:
  - mem_start while in REQ.
  - mem_ready in IDLE.
  - pc_write, reg_write and adr_src changes while busy=1 (PC and register file frozen).
- Stores:
  - Data replicated across lanes: byte in every byte lane, half in every halfword lane.
  - mem_be has size-many bits set, shifted by address offset.
- Loads:
  - Lane selected by offset, then sign- or zero-extended to XLEN, written to MDR.
  - mem_fetch=1: low 32 bits written to IR; PC at launch written to old_pc; MDR unchanged.
- rs1/rs2 latches and alu_out update every cycle, as in the existing datapath.
- Register writes to x0 are discarded.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a counter runs in REQ. After TIMEOUT_CYCLES cycles without mem_ready:
  - state returns to IDLE;
  - bus_error pulses 1 cycle;
  - mem_done is not asserted;
  - MDR and IR are unchanged.
- Undefined: no counter; REQ waits indefinitely; bus_error tied 0.

Test Plan:
1. Fetch, memory ready after 3 cycles, instruction 0x00500093 at addr 0 → mem_req high 3 cycles; instr=0x00500093, old_pc=0, mem_done pulse once.
2. LB with mem_unsigned=0, addr 0x103, rdata 0x80FFFFFF → mem_be irrelevant; MDR=0xFFFFFF80. Same with mem_unsigned=1 → MDR=0x00000080.
3. SH of 0x1234ABCD at addr 0x102 → mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we_o=1.
4. LW at addr 0x101 → misalign_fault pulse, mem_req stays 0, busy stays 0.
5. rst low during REQ → next cycle mem_req=0, PC=RESET_PC; a later mem_ready produces no mem_done.
6. MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, mem_ready held 0 → bus_error pulse after 4 REQ cycles, FSM back in IDLE, IR unchanged.

Source files
------------

// File: rtl/datapath_mem_hs.sv
// Multicycle RV datapath with a valid/ready memory port, sub-word access and misalignment rejection.
// Optional MEM_TIMEOUT_EN: abort a request after TIMEOUT_CYCLES cycles without mem_ready.
//   state | meaning
//   IDLE  | no request outstanding; mem_start accepted here
//   REQ   | mem_req held with stable address/data/enables until mem_ready (or timeout)
module datapath_mem_hs #(
  parameter int unsigned     XLEN           = 32,
  parameter int unsigned     NUM_REGS       = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              adr_src,
  input  logic [1:0]        result_src,
  input  logic [3:0]        alu_control,
  input  logic [1:0]        alu_src_a,
  input  logic [1:0]        alu_src_b,
  input  logic [2:0]        imm_src,
  input  logic              reg_write,
  input  logic              mem_start,
  input  logic              mem_we,
  input  logic              mem_fetch,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic              mem_req,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       instr,
  output logic              zero,
  output logic              busy,
  output logic              mem_done,
  output logic              misalign_fault,
  output logic              bus_error
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned RAW  = $clog2(NUM_REGS);
  localparam int unsigned SHW  = $clog2(XLEN);

  if ((XLEN != 32 && XLEN != 64) || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("datapath_mem_hs: XLEN must be 32 or 64 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] pc_q, old_pc_q, launch_pc_q, mdr_q, alu_out_q, rs1_q, rs2_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] rf_q [NUM_REGS];

  logic [XLEN-1:0] addr_q, wdata_q;
  logic [NB-1:0]   be_q;
  logic [OFFW-1:0] off_q;
  logic [1:0]      size_q;
  logic            we_q, fetch_q, uns_q;
  logic            done_q, fault_q, berr_q;

  logic [XLEN-1:0] imm_ext, src_a, src_b, alu_result, result, req_addr;
  logic [XLEN-1:0] wdata_launch, rd_shift, load_val;
  logic [31:0]     imm32;
  logic [7:0]      be_mask;
  logic [NB-1:0]   be_launch;
  logic            misaligned, launch, complete, fault_d, timeout;

  logic [RAW-1:0]  rs1_idx, rs2_idx, rd_idx;

  assign rs1_idx = ir_q[15 +: RAW];
  assign rs2_idx = ir_q[20 +: RAW];
  assign rd_idx  = ir_q[7 +: RAW];

  always_comb begin
    imm32 = '0;
    case (imm_src)
      3'd0: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      3'd1: imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      3'd2: imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      3'd3: imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      3'd4: imm32 = {ir_q[31:12], 12'b0};
      default: imm32 = '0;
    endcase
    imm_ext = XLEN'($signed(imm32));
  end

  always_comb begin
    src_a = '0;
    case (alu_src_a)
      2'd0: src_a = pc_q;
      2'd1: src_a = old_pc_q;
      2'd2: src_a = rs1_q;
      default: src_a = '0;
    endcase
    src_b = '0;
    case (alu_src_b)
      2'd0: src_b = rs2_q;
      2'd1: src_b = imm_ext;
      2'd2: src_b = XLEN'(4);
      default: src_b = '0;
    endcase
  end

  // 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass B
  always_comb begin
    alu_result = '0;
    case (alu_control)
      4'd0:  alu_result = src_a + src_b;
      4'd1:  alu_result = src_a - src_b;
      4'd2:  alu_result = src_a & src_b;
      4'd3:  alu_result = src_a | src_b;
      4'd4:  alu_result = src_a ^ src_b;
      4'd5:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'd6:  alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      4'd7:  alu_result = src_a << src_b[SHW-1:0];
      4'd8:  alu_result = src_a >> src_b[SHW-1:0];
      4'd9:  alu_result = $signed(src_a) >>> src_b[SHW-1:0];
      4'd10: alu_result = src_b;
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_comb begin
    result = '0;
    case (result_src)
      2'd0: result = alu_out_q;
      2'd1: result = mdr_q;
      2'd2: result = alu_result;
      default: result = '0;
    endcase
  end

  assign req_addr = adr_src ? result : pc_q;

  always_comb begin
    misaligned = 1'b0;
    be_mask    = 8'h01;
    wdata_launch = rs2_q;
    case (mem_size)
      2'd0: begin
        be_mask      = 8'h01;
        wdata_launch = {NB{rs2_q[7:0]}};
      end
      2'd1: begin
        misaligned   = req_addr[0];
        be_mask      = 8'h03;
        wdata_launch = {(NB/2){rs2_q[15:0]}};
      end
      2'd2: begin
        misaligned   = (req_addr[1:0] != 2'b00);
        be_mask      = 8'h0F;
        wdata_launch = {(NB/4){rs2_q[31:0]}};
      end
      default: begin
        misaligned   = (XLEN == 32) || (req_addr[2:0] != 3'b000);
        be_mask      = 8'hFF;
        wdata_launch = rs2_q;
      end
    endcase
    be_launch = NB'(be_mask) << req_addr[OFFW-1:0];
  end

  // Lane select by captured offset, then extend according to the captured size.
  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    load_val = rd_shift;
    case (size_q)
      2'd0: load_val = uns_q ? XLEN'(rd_shift[7:0])  : XLEN'($signed(rd_shift[7:0]));
      2'd1: load_val = uns_q ? XLEN'(rd_shift[15:0]) : XLEN'($signed(rd_shift[15:0]));
      2'd2: load_val = uns_q ? XLEN'(rd_shift[31:0]) : XLEN'($signed(rd_shift[31:0]));
      default: load_val = rd_shift;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (launch)
      cnt_d = CW'(TIMEOUT_CYCLES - 1);
    else if (state_q == S_REQ && !mem_ready && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  assign timeout = (state_q == S_REQ) && !mem_ready && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    complete = 1'b0;
    fault_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_start) begin
          if (misaligned) begin
            fault_d = 1'b1;
          end else begin
            launch  = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      old_pc_q    <= '0;
      launch_pc_q <= '0;
      ir_q        <= '0;
      mdr_q       <= '0;
      alu_out_q   <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      off_q       <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      fetch_q     <= 1'b0;
      uns_q       <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      rs1_q     <= rf_q[rs1_idx];
      rs2_q     <= rf_q[rs2_idx];
      alu_out_q <= alu_result;
      // Architectural state is frozen while a request is outstanding.
      if (state_q != S_REQ) begin
        if (pc_write) pc_q <= result;
        if (reg_write && rd_idx != '0) rf_q[rd_idx] <= result;
      end
      if (launch) begin
        addr_q      <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        off_q       <= req_addr[OFFW-1:0];
        size_q      <= mem_size;
        we_q        <= mem_we;
        fetch_q     <= mem_fetch;
        uns_q       <= mem_unsigned;
        wdata_q     <= wdata_launch;
        be_q        <= be_launch;
        launch_pc_q <= pc_q;
      end
      if (complete && !we_q) begin
        if (fetch_q) begin
          ir_q     <= rd_shift[31:0];
          old_pc_q <= launch_pc_q;
        end else begin
          mdr_q <= load_val;
        end
      end
      done_q  <= complete;
      fault_q <= fault_d;
      berr_q  <= timeout;
    end
  end

  assign mem_req        = (state_q == S_REQ);
  assign busy           = (state_q == S_REQ);
  assign mem_we_o       = we_q & mem_req;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_be         = be_q & {NB{mem_req}};
  assign instr          = ir_q;
  assign mem_done       = done_q;
  assign misalign_fault = fault_q;
  assign bus_error      = berr_q;

endmodule

// File: tb/tb_datapath_mem_hs.sv
// Directed + randomized bench for datapath_mem_hs (XLEN=32) against a byte-lane arithmetic model.
module tb_datapath_mem_hs;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, adr_src, reg_write, mem_start, mem_we, mem_fetch, mem_unsigned;
  logic [1:0]  result_src, alu_src_a, alu_src_b, mem_size;
  logic [3:0]  alu_control;
  logic [2:0]  imm_src;
  logic        mem_req, mem_we_o, mem_ready, zero, busy, mem_done, misalign_fault, bus_error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instr;
  logic [3:0]  mem_be;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_pc, m_old, m_ir, m_mdr;
  logic [31:0] m_regs [32];

  datapath_mem_hs #(.XLEN(32), .NUM_REGS(32), .RESET_PC(RESET_PC), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .adr_src(adr_src), .result_src(result_src),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .reg_write(reg_write), .mem_start(mem_start), .mem_we(mem_we), .mem_fetch(mem_fetch),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_req(mem_req), .mem_we_o(mem_we_o),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .instr(instr), .zero(zero), .busy(busy), .mem_done(mem_done),
    .misalign_fault(misalign_fault), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    pc_write = 0; adr_src = 0; result_src = 0; alu_control = 0; alu_src_a = 0; alu_src_b = 0;
    imm_src = 0; reg_write = 0; mem_start = 0; mem_we = 0; mem_fetch = 0; mem_size = 0;
    mem_unsigned = 0;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_old = 0; m_ir = 0; m_mdr = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rd);
    return {imm, 5'd0, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2);
    return {imm[11:5], rs2, 5'd0, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic bit is_mis(input logic [31:0] addr, input int size);
    if (size == 3) return 1'b1;
    return (addr % (1 << size)) != 0;
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] raw, input int off, input int size,
                                           input bit uns);
    longint unsigned nb, span, v;
    nb   = 64'd1 << size;
    span = 64'd1 << (8 * nb);
    v    = {32'd0, raw};
    v    = (v >> (8 * off)) & (span - 1);
    if (!uns && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] repl(input logic [31:0] v, input int size);
    if (size == 0) return {24'd0, v[7:0]} * 32'h01010101;
    if (size == 1) return {16'd0, v[15:0]} * 32'h00010001;
    return v;
  endfunction

  function automatic logic [3:0] be_of(input int off, input int size);
    int ones;
    ones = (1 << (1 << size)) - 1;
    return 4'(ones << off);
  endfunction

  task automatic fetch(input logic [31:0] word, input int lat);
    int reqs;
    idle_ctrl();
    adr_src = 0; mem_fetch = 1; mem_size = 2; mem_start = 1;
    step();
    idle_ctrl();
    chk("fetch_req", mem_req, 1);
    chk("fetch_addr", mem_addr, m_pc & ~32'd3);
    reqs = 0;
    for (int i = 0; i < lat; i++) begin
      if (mem_req) reqs++;
      step();
    end
    if (mem_req) reqs++;
    mem_rdata = word; mem_ready = 1;
    step();
    mem_ready = 0; mem_rdata = $urandom;
    m_ir = word; m_old = m_pc;
    chk("fetch_done", mem_done, 1);
    chk("fetch_req_cycles", reqs, lat + 1);
    chk("fetch_instr", instr, m_ir);
    step();
    chk("fetch_done_pulse", mem_done, 0);
  endtask

  task automatic advance_pc();
    pc_write = 1; alu_src_a = 1; alu_src_b = 2; alu_control = 0; result_src = 2;
    step();
    idle_ctrl();
    m_pc = m_old + 4;
  endtask

  task automatic mem_op(input bit we, input int size, input bit uns, input int lat,
                        input logic [31:0] rdata, input logic [31:0] addr);
    idle_ctrl();
    alu_src_a = 2; alu_src_b = 1; imm_src = we ? 3'd1 : 3'd0; alu_control = 0; result_src = 2;
    adr_src = 1; mem_we = we; mem_size = 2'(size); mem_unsigned = uns; mem_start = 1;
    step();
    idle_ctrl();
    if (is_mis(addr, size)) begin
      chk("mis_fault", misalign_fault, 1);
      chk("mis_req", mem_req, 0);
      chk("mis_busy", busy, 0);
      step();
      chk("mis_fault_pulse", misalign_fault, 0);
      chk("mis_no_done", mem_done, 0);
    end else begin
      chk("op_req", mem_req, 1);
      chk("op_busy", busy, 1);
      chk("op_we", mem_we_o, we);
      chk("op_addr", mem_addr, addr & ~32'd3);
      chk("op_be", mem_be, be_of(addr % 4, size));
      if (we) chk("op_wdata", mem_wdata, repl(m_regs[m_ir[24:20]], size));
      for (int i = 0; i < lat; i++) begin
        pc_write = 1; reg_write = 1; result_src = 2; alu_src_a = 0; alu_src_b = 2;
        adr_src = 1'($urandom);
        step();
        chk("op_hold_req", mem_req, 1);
        chk("op_hold_addr", mem_addr, addr & ~32'd3);
      end
      idle_ctrl();
      mem_rdata = rdata; mem_ready = 1;
      step();
      mem_ready = 0;
      chk("op_done", mem_done, 1);
      chk("op_req_drop", mem_req, 0);
      if (!we) m_mdr = ext_load(rdata, addr % 4, size, uns);
      step();
      chk("op_done_pulse", mem_done, 0);
    end
  endtask

  task automatic writeback();
    result_src = 1; reg_write = 1;
    step();
    idle_ctrl();
    if (m_ir[11:7] != 0) m_regs[m_ir[11:7]] = m_mdr;
  endtask

  task automatic load_to_reg(input logic [4:0] rd, input logic [31:0] addr, input int size,
                             input bit uns, input logic [31:0] rdata, input int lat);
    fetch(enc_i(addr[11:0], rd), $urandom_range(0, 2));
    advance_pc();
    mem_op(1'b0, size, uns, lat, rdata, addr);
    writeback();
  endtask

  task automatic store_from_reg(input logic [4:0] rs2, input logic [31:0] addr, input int size,
                                input int lat);
    fetch(enc_s(addr[11:0], rs2), $urandom_range(0, 2));
    advance_pc();
    step();
    mem_op(1'b1, size, 1'b0, lat, $urandom, addr);
  endtask

  initial begin
    int cnt;
    idle_ctrl();
    mem_ready = 0; mem_rdata = 0;
    rst = 0;
    model_reset();
    step(); step();
    rst = 1;
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_instr", instr, 0);
    chk("rst_done", mem_done, 0);
    chk("rst_fault", misalign_fault, 0);
    chk("rst_berr", bus_error, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);

    // Fetch of addi x1,x0,5 with memory ready after 3 request cycles
    fetch(32'h00500093, 2);
    alu_src_a = 2; alu_src_b = 1; imm_src = 0; alu_control = 0;
    #1;
    chk("zero_imm", zero, (m_ir[31:20] == 0));
    alu_src_b = 0;
    #1;
    chk("zero_rs2", zero, (m_regs[m_ir[24:20]] == 0));
    idle_ctrl();
    advance_pc();
    alu_src_a = 2; alu_src_b = 1; imm_src = 0; alu_control = 0; result_src = 2; reg_write = 1;
    step();
    idle_ctrl();
    m_regs[1] = m_regs[0] + {{20{m_ir[31]}}, m_ir[31:20]};
    store_from_reg(5'd1, 32'h100, 2, 0);

    // Signed and unsigned byte load from the top lane
    load_to_reg(5'd5, 32'h103, 0, 1'b0, 32'h80FFFFFF, 1);
    store_from_reg(5'd5, 32'h200, 2, 0);
    load_to_reg(5'd6, 32'h103, 0, 1'b1, 32'h80FFFFFF, 0);
    store_from_reg(5'd6, 32'h204, 2, 1);

    // Halfword store into the upper lane
    load_to_reg(5'd7, 32'h104, 2, 1'b0, 32'h1234ABCD, 0);
    store_from_reg(5'd7, 32'h102, 1, 1);

    // Misaligned word load is rejected
    load_to_reg(5'd3, 32'h101, 2, 1'b0, 32'hDEADBEEF, 0);
    store_from_reg(5'd3, 32'h208, 2, 0);

    // x0 stays zero
    load_to_reg(5'd0, 32'h10, 2, 1'b0, 32'hFFFFFFFF, 0);
    store_from_reg(5'd0, 32'h20C, 2, 0);

    for (int it = 0; it < 24; it++) begin
      logic [4:0]  rd;
      logic [31:0] la, sa;
      int          lsz, ssz;
      rd  = 5'($urandom_range(0, 31));
      lsz = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      ssz = $urandom_range(0, 2);
      la  = 32'($urandom_range(0, 32'h7FF));
      sa  = 32'($urandom_range(0, 32'h7FF));
      if ($urandom_range(0, 1) == 1) la = la & ~32'd3;
      if ($urandom_range(0, 1) == 1) sa = sa & ~32'd3;
      load_to_reg(rd, la, lsz, 1'($urandom), $urandom, $urandom_range(0, 3));
      store_from_reg(rd, sa, ssz, $urandom_range(0, 3));
    end

    // Reset while a request is in flight
    idle_ctrl();
    adr_src = 0; mem_fetch = 1; mem_size = 2; mem_start = 1;
    step();
    idle_ctrl();
    chk("rreq_active", mem_req, 1);
    step();
    rst = 0;
    step();
    rst = 1;
    model_reset();
    chk("rreq_req", mem_req, 0);
    chk("rreq_busy", busy, 0);
    chk("rreq_instr", instr, m_ir);
    mem_rdata = 32'h12345678; mem_ready = 1;
    step();
    mem_ready = 0;
    chk("rreq_no_done", mem_done, 0);
    chk("rreq_instr_kept", instr, m_ir);
    step();
    chk("rreq_no_done2", mem_done, 0);
    fetch(enc_s(12'h040, 5'd9), 0);
    advance_pc();
    step();
    mem_op(1'b1, 2, 1'b0, 0, 32'h0, 32'h40);

    // Request with mem_ready held low
    idle_ctrl();
    adr_src = 0; mem_fetch = 1; mem_size = 2; mem_start = 1;
    step();
    idle_ctrl();
    cnt = 0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 20 && mem_req; i++) begin
      cnt++;
      step();
    end
    chk("to_req_cycles", cnt, 4);
    chk("to_berr", bus_error, 1);
    chk("to_no_done", mem_done, 0);
    chk("to_busy", busy, 0);
    chk("to_instr", instr, m_ir);
    step();
    chk("to_berr_pulse", bus_error, 0);
`else
    for (int i = 0; i < 10 && mem_req; i++) begin
      cnt++;
      chk("wait_no_berr", bus_error, 0);
      step();
    end
    chk("wait_req_cycles", cnt, 10);
    chk("wait_still_req", mem_req, 1);
    mem_rdata = enc_i(12'h0, 5'd0); mem_ready = 1;
    step();
    mem_ready = 0;
    m_ir = enc_i(12'h0, 5'd0); m_old = m_pc;
    chk("wait_done", mem_done, 1);
    chk("wait_instr", instr, m_ir);
    step();
`endif
    chk("end_instr", instr, m_ir);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
